// File: rtl/edge_stream_fetch.sv
`timescale 1ns/1ps
// edge_stream_fetch: issues one read per edge of a source vertex, buffers responses in order, emits one beat per edge.
// Build option: define EDGE_STREAM_ZERO_DEGREE_PASSTHRU_EN to emit an empty-marker beat for zero-degree vertices.
module edge_stream_fetch #(
  parameter int ADDR_W = 64,
  parameter int ID_W   = 64,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32,
  parameter int STRIDE = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ID_W-1:0]   in_vertex_id,
  input  logic [ADDR_W-1:0] in_edge_addr,
  input  logic [CNT_W-1:0]  in_num_edges,
  input  logic [ID_W-1:0]   in_edge_base,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [ID_W-1:0]   mem_rsp_dst_id,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_vertex_id,
  output logic [ID_W-1:0]   out_dst_id,
  output logic [ID_W-1:0]   out_edge_id,
  output logic [DATA_W-1:0] out_edge_data,
  output logic              out_last_edge,
  output logic              out_edges_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic [ID_W-1:0]   dst_id;
    logic [DATA_W-1:0] data;
  } rsp_t;

  state_t            state, state_nxt;
  rsp_t              fifo_mem [DEPTH];
  rsp_t              head;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_cnt, outstanding;
  logic [ID_W-1:0]   vertex_id, edge_base;
  logic [ADDR_W-1:0] edge_addr;
  logic [CNT_W-1:0]  num_edges, issue_idx, out_idx;
  logic              err, zero_pend;
  logic              in_fire, req_fire, rsp_push, pop, out_fire;
  logic              fifo_nonempty, credits_avail, last_issue, last_out;

  assign in_ready      = (state == IDLE);
  assign in_fire       = in_valid && in_ready;
  // Outstanding reads reserve a FIFO slot, so a response can always be pushed.
  assign credits_avail = (outstanding + fifo_cnt) != DEPTH_C;
  assign mem_req_valid = (state == ISSUE) && credits_avail;
  assign mem_req_addr  = edge_addr + ADDR_W'(issue_idx) * ADDR_W'(STRIDE);
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rsp_push      = mem_rsp_valid && (outstanding != '0);
  assign fifo_nonempty = (fifo_cnt != '0);
  assign out_valid     = fifo_nonempty || zero_pend;
  assign out_fire      = out_valid && out_ready;
  assign pop           = out_fire && fifo_nonempty;
  assign last_issue    = (issue_idx == num_edges - CNT_W'(1));
  assign last_out      = (out_idx == num_edges - CNT_W'(1));

  // Data outputs are gated to zero when no real beat is presented.
  assign head            = fifo_mem[rd_ptr];
  assign out_vertex_id   = out_valid ? vertex_id : '0;
  assign out_dst_id      = fifo_nonempty ? head.dst_id : '0;
  assign out_edge_data   = fifo_nonempty ? head.data : '0;
  assign out_edge_id     = fifo_nonempty ? edge_base + ID_W'(out_idx) : '0;
  assign out_last_edge   = (fifo_nonempty && last_out) || zero_pend;
  assign out_edges_empty = zero_pend;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_fire) begin
          if (in_num_edges != '0) state_nxt = ISSUE;
`ifdef EDGE_STREAM_ZERO_DEGREE_PASSTHRU_EN
          else                    state_nxt = DRAIN;
`endif
        end
      end
      ISSUE:   if (req_fire && last_issue)    state_nxt = DRAIN;
      DRAIN:   if (out_fire && out_last_edge) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      vertex_id   <= '0;
      edge_base   <= '0;
      edge_addr   <= '0;
      num_edges   <= '0;
      issue_idx   <= '0;
      out_idx     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_fire) begin
        vertex_id <= in_vertex_id;
        edge_base <= in_edge_base;
        edge_addr <= in_edge_addr;
        num_edges <= in_num_edges;
        issue_idx <= '0;
        out_idx   <= '0;
      end else begin
        if (req_fire) issue_idx <= issue_idx + CNT_W'(1);
        if (pop)      out_idx   <= out_idx + CNT_W'(1);
      end
      if (rsp_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt    <= fifo_cnt + CW'(rsp_push) - CW'(pop);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_push);
      if (mem_rsp_valid && outstanding == '0) err <= 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (rsp_push) fifo_mem[wr_ptr] <= '{dst_id: mem_rsp_dst_id, data: mem_rsp_data};
  end

`ifdef EDGE_STREAM_ZERO_DEGREE_PASSTHRU_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 zero_pend <= 1'b0;
    else if (in_fire && in_num_edges == '0)    zero_pend <= 1'b1;
    else if (out_fire)                         zero_pend <= 1'b0;
  end
`else
  assign zero_pend = 1'b0;
`endif

  // A response with no outstanding read is an upstream protocol violation.
  no_stray_rsp: assert property (@(posedge clk) disable iff (reset) !err);

endmodule

// File: tb/tb_edge_stream_fetch.sv
`timescale 1ns/1ps
// Self-checking bench for edge_stream_fetch: table of descriptors plus hand-written stall and reset sequences.
module tb_edge_stream_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_vertex_id = '0, in_edge_addr = '0, in_edge_base = '0;
  logic [31:0] in_num_edges = '0;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rsp_dst_id = '0, mem_rsp_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [63:0] out_vertex_id, out_dst_id, out_edge_id, out_edge_data;
  logic        out_last_edge, out_edges_empty;

  edge_stream_fetch dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_vertex_id(in_vertex_id),
    .in_edge_addr(in_edge_addr), .in_num_edges(in_num_edges), .in_edge_base(in_edge_base),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_dst_id(mem_rsp_dst_id), .mem_rsp_data(mem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_vertex_id(out_vertex_id),
    .out_dst_id(out_dst_id), .out_edge_id(out_edge_id), .out_edge_data(out_edge_data),
    .out_last_edge(out_last_edge), .out_edges_empty(out_edges_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] vid, dst, eid, data;
    logic        last, empty;
  } beat_t;

  typedef struct {
    int          due;
    logic [63:0] addr;
  } pend_t;

  typedef struct {
    logic [63:0] vid, addr;
    logic [31:0] num;
    logic [63:0] base;
    int          lat, rdy_mode, req_mode, exp_beats;
    logic [63:0] exp_last_addr;
    bit          b2b;
  } vec_t;

  int          checks = 0, errors = 0;
  int          cyc = 0;
  int          lat = 1, rdy_mode = 0, req_mode = 0;
  int          req_count = 0, beat_count = 0, first_req_cyc = -1, last_req_cyc = 0, last_pop_cyc = 0;
  logic [63:0] last_req_addr = '0;
  beat_t       sb[$];
  logic [63:0] exp_req[$];
  pend_t       pend[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mem_dst(input logic [63:0] a);
    return a ^ 64'hA5A5_0000_0000_0000;
  endfunction

  function automatic logic [63:0] mem_data(input logic [63:0] a);
    return a + 64'h1_0000_0007;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: owns the request ready and the in-order response channel.
  initial begin : mem_model
    logic        stall = 1'b0;
    logic [63:0] held_addr = '0;
    pend_t       r;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend.delete();
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
        stall = 1'b0;
        continue;
      end
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        r = pend.pop_front();
        mem_rsp_valid  = 1'b1;
        mem_rsp_dst_id = mem_dst(r.addr);
        mem_rsp_data   = mem_data(r.addr);
      end else begin
        mem_rsp_valid = 1'b0;
      end
      case (req_mode)
        0:       mem_req_ready = 1'b1;
        1:       mem_req_ready = ~mem_req_ready;
        default: mem_req_ready = 1'($urandom_range(0, 1));
      endcase
      if (stall) check("req_held", {mem_req_valid, mem_req_addr == held_addr}, 2'b11);
      stall = 1'b0;
      if (mem_req_valid) begin
        if (first_req_cyc < 0) first_req_cyc = cyc;
        if (mem_req_ready) begin
          check("req_expected", (exp_req.size() != 0), 1'b1);
          if (exp_req.size() != 0) check("req_addr", mem_req_addr, exp_req.pop_front());
          req_count++;
          last_req_addr = mem_req_addr;
          last_req_cyc  = cyc;
          pend.push_back('{due: cyc + lat, addr: mem_req_addr});
        end else begin
          stall     = 1'b1;
          held_addr = mem_req_addr;
        end
      end
    end
  end

  // Output monitor: owns out_ready and pops the scoreboard on each accepted beat.
  initial begin : monitor
    logic  stall = 1'b0;
    beat_t cur, held, e;
    forever begin
      @(negedge clk);
      if (reset) begin
        out_ready = 1'b0;
        stall = 1'b0;
        continue;
      end
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      cur = '{out_vertex_id, out_dst_id, out_edge_id, out_edge_data, out_last_edge, out_edges_empty};
      if (stall) check("out_held", {out_valid, cur == held}, 2'b11);
      stall = 1'b0;
      if (out_valid && out_ready) begin
        check("beat_expected", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("beat_vertex", cur.vid, e.vid);
          check("beat_edge_id", cur.eid, e.eid);
          check("beat_dst", cur.dst, e.dst);
          check("beat_data", cur.data, e.data);
          check("beat_flags", {cur.last, cur.empty}, {e.last, e.empty});
        end
        beat_count++;
        if (out_last_edge) last_pop_cyc = cyc;
      end else if (out_valid) begin
        stall = 1'b1;
        held  = cur;
      end
    end
  end

  task automatic send_desc(input logic [63:0] vid, input logic [63:0] addr, input logic [31:0] num,
                           input logic [63:0] base, output int t);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_send", in_ready, 1'b1);
    in_valid = 1'b1;
    in_vertex_id = vid;
    in_edge_addr = addr;
    in_num_edges = num;
    in_edge_base = base;
    t = cyc;
    for (int i = 0; i < int'(num); i++) begin
      logic [63:0] a;
      a = addr + 64'(i) * 64'd16;
      exp_req.push_back(a);
      sb.push_back('{vid, mem_dst(a), base + 64'(i), mem_data(a), (i == int'(num) - 1), 1'b0});
    end
`ifdef EDGE_STREAM_ZERO_DEGREE_PASSTHRU_EN
    if (num == 0) sb.push_back('{vid, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1});
`endif
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int rise_cyc);
    int n = 0;
    while (!(in_ready && sb.size() == 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_in_bound", (n < 3000), 1'b1);
    rise_cyc = cyc;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t vecs[6];
    int   t, rise;
    int   zero_beats;
`ifdef EDGE_STREAM_ZERO_DEGREE_PASSTHRU_EN
    zero_beats = 1;
`else
    zero_beats = 0;
`endif
    vecs[0] = '{64'd7,  64'h1000, 32'd3,  64'd20,  2, 0, 0, 3,  64'h1020, 1'b1};
    vecs[1] = '{64'd9,  64'h2000, 32'd10, 64'd100, 1, 0, 1, 10, 64'h2090, 1'b0};
    vecs[2] = '{64'd11, 64'hFFFF_FFFF_FFFF_FFF0, 32'd2, 64'd5, 3, 0, 0, 2, 64'h0, 1'b1};
    vecs[3] = '{64'd12, 64'h3000, 32'd6,  64'd0,   5, 2, 2, 6,  64'h3050, 1'b0};
    vecs[4] = '{64'd13, 64'h4000, 32'd1,  64'd77,  1, 0, 0, 1,  64'h4000, 1'b1};
    vecs[5] = '{64'd14, 64'h5000, 32'd0,  64'd9,   1, 0, 0, zero_beats, 64'h0, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_req_addr", mem_req_addr, 64'h0);
    check("rst_out_ids", out_vertex_id | out_dst_id | out_edge_id | out_edge_data, 64'h0);
    check("rst_out_flags", {out_last_edge, out_edges_empty}, 2'b00);
    #2 reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      lat = vecs[v].lat;
      rdy_mode = vecs[v].rdy_mode;
      req_mode = vecs[v].req_mode;
      req_count = 0;
      beat_count = 0;
      first_req_cyc = -1;
      send_desc(vecs[v].vid, vecs[v].addr, vecs[v].num, vecs[v].base, t);
      wait_done(rise);
      check("vec_beats", 64'(beat_count), 64'(vecs[v].exp_beats));
      check("vec_reqs", 64'(req_count), 64'(vecs[v].num));
      if (vecs[v].num != 0) begin
        check("vec_last_addr", last_req_addr, vecs[v].exp_last_addr);
        check("first_req_latency", 64'(first_req_cyc - t), 64'd1);
        check("in_ready_after_last_pop", 64'(rise - last_pop_cyc), 64'd1);
        if (vecs[v].b2b) check("req_back_to_back", 64'(last_req_cyc - first_req_cyc), 64'(vecs[v].num - 1));
      end else if (zero_beats == 1) begin
        check("zero_in_ready_after_pop", 64'(rise - last_pop_cyc), 64'd1);
      end else begin
        repeat (3) @(negedge clk);
        check("zero_stays_idle", {in_ready, out_valid}, 2'b10);
      end
    end

    // Reset while draining with two beats buffered.
    lat = 1; rdy_mode = 1; req_mode = 0;
    send_desc(64'd30, 64'h6000, 32'd2, 64'd0, t);
    repeat (8) @(negedge clk);
    check("pre_reset_valid", {out_valid, in_ready}, 2'b10);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_out_valid", out_valid, 1'b0);
    check("mid_reset_in_ready", in_ready, 1'b1);
    check("mid_reset_req_valid", mem_req_valid, 1'b0);
    sb.delete();
    exp_req.delete();
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    // Credits back at DEPTH: with output stalled exactly four reads issue, then issue resumes.
    lat = 2; rdy_mode = 1; req_mode = 0;
    req_count = 0;
    beat_count = 0;
    send_desc(64'd31, 64'h7000, 32'd10, 64'd40, t);
    repeat (20) @(negedge clk);
    check("stalled_req_count", 64'(req_count), 64'd4);
    check("stalled_req_valid", mem_req_valid, 1'b0);
    check("stalled_out_valid", out_valid, 1'b1);
    rdy_mode = 0;
    wait_done(rise);
    check("resumed_beats", 64'(beat_count), 64'd10);
    check("resumed_reqs", 64'(req_count), 64'd10);
    check("resumed_in_ready_after_last_pop", 64'(rise - last_pop_cyc), 64'd1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_stream_fetch.md
# edge_stream_fetch

- Parametrised successor to the source-edge read stage of the graph pipeline. Sits between the source-property stage and the destination-property stage.
- Accepts one source vertex descriptor: vertex id, edge-list base address, edge count, base edge id.
- Issues one memory read per edge, with up to DEPTH reads in flight. Responses are buffered in an in-order FIFO.
- Emits one pipeline beat per edge downstream, with `last_edge` tagging and backpressure.

## Interface

Parameters:
- ADDR_W, 64, memory address width
- ID_W, 64, vertex/edge id width
- DATA_W, 64, edge weight width
- CNT_W, 32, edge-count width
- STRIDE, 16, bytes between consecutive edge records
- DEPTH, 4, response FIFO depth and maximum outstanding reads; power of two, ≥2

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  descriptor valid
- in_ready  out  1  stage can accept a descriptor (p_stall_can_accept)
- in_vertex_id  in  ID_W  source vertex id
- in_edge_addr  in  ADDR_W  address of first edge record
- in_num_edges  in  CNT_W  out-degree
- in_edge_base  in  ID_W  edge id of first edge
- mem_req_valid  out  1  read request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  request address
- mem_rsp_valid  in  1  read data returned, in order; cannot be stalled
- mem_rsp_dst_id  in  ID_W  destination vertex id of edge
- mem_rsp_data  in  DATA_W  edge weight
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream can accept (n_stall_can_accept)
- out_vertex_id, out_dst_id, out_edge_id  out  ID_W  beat fields
- out_edge_data  out  DATA_W  edge weight
- out_last_edge  out  1  final beat of this vertex
- out_edges_empty  out  1  zero-degree marker beat

## Operation

- State machine IDLE → ISSUE → DRAIN → IDLE.
- IDLE: `in_ready`=1.
  - Handshake (`in_valid`&&`in_ready`) latches all descriptor fields, clears the issue index and output index.
  - If `in_num_edges`≠0, go to ISSUE.
  - If `in_num_edges`=0, behaviour is set by the configuration macro (see Configuration).
- ISSUE:
  - `mem_req_valid`=1 when credits>0.
  - `mem_req_addr` = base + idx·STRIDE, modulo 2^ADDR_W.
  - On request handshake, idx increments. When the last request handshakes (idx = num_edges−1), go to DRAIN.
- Credits = DEPTH − (outstanding reads + FIFO occupancy). Responses can therefore never overflow the FIFO.
- Each `mem_rsp_valid` pushes {dst_id, data} into the FIFO.
- Output beat comes from the FIFO head (first-word fall-through). Fields:
  - `out_vertex_id` = latched vertex id.
  - `out_edge_id` = edge_base + output index.
  - `out_last_edge` = (output index = num_edges−1).
  - A pop occurs on `out_valid`&&`out_ready`.
- DRAIN: go to IDLE on the cycle the last beat pops. `in_ready` rises the following cycle; a new vertex is not overlapped with the previous one.
- Simultaneous push and pop on the same cycle: occupancy is unchanged, and credits include the popped slot on the next cycle.
- A `mem_rsp_valid` with no outstanding request is a protocol error. It is ignored, and the sticky internal `err` flag is set for assertion visibility.

## Timing

- Reset values (asynchronous reset):
  - state=IDLE, `in_ready`=1.
  - `mem_req_valid`=0, `out_valid`=0, FIFO empty, credits=DEPTH.
  - All data outputs 0.
- Reset mid-operation drops all in-flight reads and buffered beats. Responses arriving after reset deasserts are treated as protocol errors.
- Descriptor accepted at cycle T → first `mem_req_valid` at T+1.
- Response at cycle R → `out_valid` at R+1.
- Sustained throughput is 1 edge/cycle when memory latency < DEPTH cycles and `out_ready`=1.
- `mem_req_valid` and `mem_req_addr` stay stable until `mem_req_ready`.
- `out_*` stays stable while `out_valid`&&!`out_ready`.
- `num_edges` up to 2^CNT_W−1. Index counters are CNT_W bits and never wrap within one vertex.

## Configuration

- Macro: `EDGE_STREAM_ZERO_DEGREE_PASSTHRU_EN`.
- Defined: a zero-degree descriptor goes IDLE → DRAIN and produces exactly one beat with:
  - `out_edges_empty`=1, `out_last_edge`=1.
  - dst_id, edge_id and edge_data = 0.
  - The state machine returns to IDLE after that beat pops.
- Undefined: a zero-degree descriptor is consumed with no output beat and the state machine stays in IDLE. `out_edges_empty` is tied to 0.

## Test plan

- Descriptor vertex=7, addr=0x1000, num=3, base=20; memory latency 2; `out_ready`=1 → requests to 0x1000, 0x1010, 0x1020 on consecutive cycles; 3 beats with edge_id 20, 21, 22; last_edge only on edge 22; `in_ready` returns 1 cycle after the third pop.
- num=10, DEPTH=4, `out_ready`=0 → exactly 4 requests issue, then `mem_req_valid` stays 0. Raising `out_ready` resumes issue; all 10 beats arrive in order.
- `mem_req_ready` toggling 1/0 → address held stable while stalled; no request skipped or duplicated.
- num=0 → with the macro defined, one beat with edges_empty=1, last_edge=1; without it, no beat and `in_ready` remains 1.
- Reset asserted in DRAIN with 2 beats buffered → `out_valid`=0 immediately, `in_ready`=1, credits=DEPTH.
- Address wrap: addr = 2^64−16, num=2 → second request to address 0x0.
